// File: rtl/audio_frame_streamer_pkg.sv
// Shared definitions for the audio frame streamer: register map, CTRL/STATUS
// bit positions, output FSM states and the channel-index width helper.
package audio_frame_streamer_pkg;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_CTRL     = 2'd1;
    localparam logic [1:0] ADDR_STATUS   = 2'd2;
    localparam logic [1:0] ADDR_UNDERRUN = 2'd3;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_FLUSH_BIT  = 1;
    localparam int CTRL_IRQ_EN_BIT = 2;

    localparam int STATUS_FULL_BIT  = 16;
    localparam int STATUS_EMPTY_BIT = 17;
    localparam int STATUS_OVF_BIT   = 18;
    localparam int STATUS_IRQ_BIT   = 19;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND
    } state_t;

    // A single-channel stream still needs a one-bit channel field.
    function automatic int ch_w(input int num_ch);
        return (num_ch <= 2) ? 1 : $clog2(num_ch);
    endfunction

endpackage

// File: rtl/audio_frame_streamer_frame_fifo.sv
// Synchronous frame FIFO: one whole interleaved frame per word, with flush,
// full/empty flags and an occupancy level in frames.
module frame_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO still succeeds when a pop frees a slot this cycle.
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign full     = (count == LW'(DEPTH));
    assign empty    = (count == '0);
    assign level    = count;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/audio_frame_streamer.sv
// Avalon-MM to Avalon-ST audio frame streamer with underrun silence, overflow
// detection and flush. The low-watermark interrupt is built only when
// AUDIO_FRAME_STREAMER_IRQ_EN is defined.
module audio_frame_streamer
    import audio_frame_streamer_pkg::*;
#(
    parameter  int NUM_CH   = 2,
    parameter  int SAMPLE_W = 16,
    parameter  int DEPTH    = 64,
    parameter  int LOW_WM   = 16,
    localparam int CH_W     = ch_w(NUM_CH),
    localparam int FRAME_W  = NUM_CH * SAMPLE_W,
    localparam int LVL_W    = $clog2(DEPTH) + 1
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    input  logic [1:0]          avs_address,
    input  logic                avs_write,
    input  logic [31:0]         avs_writedata,
    input  logic                avs_read,
    output logic [31:0]         avs_readdata,
    output logic [SAMPLE_W-1:0] aso_data,
    output logic [CH_W-1:0]     aso_channel,
    output logic                aso_startofpacket,
    output logic                aso_endofpacket,
    output logic                aso_valid,
    input  logic                aso_ready,
    output logic                irq
);

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    state_t             state;
    state_t             state_next;
    logic               en;
    logic               irq_en;
    logic               irq_q;
    logic               ovf;
    logic [15:0]        underrun;
    logic [CH_W-1:0]    wr_slot;
    logic [CH_W-1:0]    ch;
    logic [FRAME_W-1:0] asm_frame;
    logic [FRAME_W-1:0] push_frame;
    logic [FRAME_W-1:0] pop_frame;
    logic [FRAME_W-1:0] out_frame;
    logic [LVL_W-1:0]   level;
    logic [31:0]        read_word;
    logic               ctrl_wr;
    logic               status_wr;
    logic               underrun_wr;
    logic               flush;
    logic               data_wr;
    logic               frame_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic               last_ch;
    logic               unused_wdata;

    assign unused_wdata = ^avs_writedata;

    assign ctrl_wr     = avs_write && (avs_address == ADDR_CTRL);
    assign status_wr   = avs_write && (avs_address == ADDR_STATUS);
    assign underrun_wr = avs_write && (avs_address == ADDR_UNDERRUN);
    assign flush       = ctrl_wr && avs_writedata[CTRL_FLUSH_BIT];
    assign data_wr     = avs_write && (avs_address == ADDR_DATA) && !flush;
    assign frame_push  = data_wr && (wr_slot == LAST_CH);
    assign last_ch     = (ch == LAST_CH);

    // The final sample bypasses the assembly register so the frame pushes on its write.
    always_comb begin
        push_frame = asm_frame;
        push_frame[(NUM_CH-1)*SAMPLE_W +: SAMPLE_W] = avs_writedata[SAMPLE_W-1:0];
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wr_slot   <= '0;
            asm_frame <= '0;
        end else if (flush) begin
            wr_slot <= '0;
        end else if (data_wr) begin
            asm_frame[int'(wr_slot)*SAMPLE_W +: SAMPLE_W] <= avs_writedata[SAMPLE_W-1:0];
            wr_slot <= (wr_slot == LAST_CH) ? '0 : wr_slot + 1'b1;
        end
    end

    frame_fifo #(
        .WIDTH(FRAME_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk_clk),
        .rst_n     (reset_reset_n),
        .flush     (flush),
        .push      (frame_push),
        .push_data (push_frame),
        .pop       (fifo_pop),
        .pop_data  (pop_frame),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            en       <= 1'b0;
            ovf      <= 1'b0;
            underrun <= '0;
        end else begin
            if (ctrl_wr) begin
                en <= avs_writedata[CTRL_EN_BIT];
            end
            if (frame_push && fifo_full && !fifo_pop) begin
                ovf <= 1'b1;
            end else if (status_wr && avs_writedata[STATUS_OVF_BIT]) begin
                ovf <= 1'b0;
            end
            if (underrun_wr) begin
                underrun <= '0;
            end else if (state == LOAD && fifo_empty && underrun != 16'hFFFF) begin
                underrun <= underrun + 1'b1;
            end
        end
    end

`ifdef AUDIO_FRAME_STREAMER_IRQ_EN
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            irq_en <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                irq_en <= avs_writedata[CTRL_IRQ_EN_BIT];
            end
            irq_q <= irq_en && en && ((level < LVL_W'(LOW_WM)) || ovf);
        end
    end
`else
    assign irq_en = 1'b0;
    assign irq_q  = 1'b0;
`endif

    assign irq = irq_q;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A frame always runs to its last channel; EN is only sampled at frame boundaries.
    always_comb begin
        state_next = state;
        aso_valid  = 1'b0;
        fifo_pop   = 1'b0;
        unique case (state)
            IDLE: begin
                if (en) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                fifo_pop   = !fifo_empty;
                state_next = SEND;
            end
            SEND: begin
                aso_valid = 1'b1;
                if (aso_ready && last_ch) begin
                    state_next = en ? LOAD : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            ch        <= '0;
            out_frame <= '0;
        end else if (state == LOAD) begin
            ch        <= '0;
            out_frame <= fifo_empty ? '0 : pop_frame;
        end else if (state == SEND && aso_ready && !last_ch) begin
            ch <= ch + 1'b1;
        end
    end

    assign aso_data          = out_frame[int'(ch)*SAMPLE_W +: SAMPLE_W];
    assign aso_channel       = ch;
    assign aso_startofpacket = aso_valid && (ch == '0);
    assign aso_endofpacket   = aso_valid && last_ch;

    always_comb begin
        read_word = '0;
        unique case (avs_address)
            ADDR_CTRL: begin
                read_word[CTRL_EN_BIT]     = en;
                read_word[CTRL_IRQ_EN_BIT] = irq_en;
            end
            ADDR_STATUS: begin
                read_word[15:0]             = 16'(level);
                read_word[STATUS_FULL_BIT]  = fifo_full;
                read_word[STATUS_EMPTY_BIT] = fifo_empty;
                read_word[STATUS_OVF_BIT]   = ovf;
                read_word[STATUS_IRQ_BIT]   = irq_q;
            end
            ADDR_UNDERRUN: begin
                read_word[15:0] = underrun;
            end
            default: read_word = '0;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            avs_readdata <= '0;
        end else if (avs_read) begin
            avs_readdata <= read_word;
        end
    end

endmodule

// File: tb/tb_audio_frame_streamer.sv
// Scoreboard bench for audio_frame_streamer (NUM_CH=2, SAMPLE_W=16, DEPTH=64,
// LOW_WM=16); irq expectations follow AUDIO_FRAME_STREAMER_IRQ_EN.
module tb_audio_frame_streamer;
    import audio_frame_streamer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  avs_address = '0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic        avs_read = 1'b0;
    logic [31:0] avs_readdata;
    logic [15:0] aso_data;
    logic [0:0]  aso_channel;
    logic        aso_startofpacket;
    logic        aso_endofpacket;
    logic        aso_valid;
    logic        aso_ready = 1'b0;
    logic        irq;

    int checks = 0;
    int failures = 0;

    // Each expected beat is {sop, eop, channel, data}.
    logic [18:0] exp_q[$];

    always #5 clk = ~clk;

    audio_frame_streamer #(
        .NUM_CH(2),
        .SAMPLE_W(16),
        .DEPTH(64),
        .LOW_WM(16)
    ) dut (
        .clk_clk           (clk),
        .reset_reset_n     (rst_n),
        .avs_address       (avs_address),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_read          (avs_read),
        .avs_readdata      (avs_readdata),
        .aso_data          (aso_data),
        .aso_channel       (aso_channel),
        .aso_startofpacket (aso_startofpacket),
        .aso_endofpacket   (aso_endofpacket),
        .aso_valid         (aso_valid),
        .aso_ready         (aso_ready),
        .irq               (irq)
    );

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, actual, expected);
        end
    endtask

    task automatic push_frame(input logic [15:0] s0, input logic [15:0] s1);
        exp_q.push_back({1'b1, 1'b0, 1'b0, s0});
        exp_q.push_back({1'b0, 1'b1, 1'b1, s1});
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        avs_address   = addr;
        avs_writedata = data;
        avs_write     = 1'b1;
        @(posedge clk);
        #1;
        avs_write = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
        avs_address = addr;
        avs_read    = 1'b1;
        @(posedge clk);
        #1;
        avs_read = 1'b0;
        data     = avs_readdata;
    endtask

    task automatic read_check(input string name, input logic [1:0] addr,
                              input logic [31:0] expected);
        logic [31:0] data;
        bus_read(addr, data);
        check_output(name, data, expected);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!aso_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!aso_valid) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s timeout actual=valid_low required=valid_high", name);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Enables the stream, accepts n frames, and drops EN during the last one.
    task automatic stream_frames(input int n, input int stall);
        bus_write(ADDR_CTRL, 32'h1);
        for (int f = 0; f < n; f++) begin
            wait_valid("stream_wait");
            if (f == n - 1) begin
                bus_write(ADDR_CTRL, 32'h0);
            end
            aso_ready = 1'b1;
            tick(1);
            if (stall > 0) begin
                aso_ready = 1'b0;
                tick(stall);
                aso_ready = 1'b1;
            end
            tick(1);
            aso_ready = 1'b0;
        end
        tick(3);
    endtask

    // Monitor: accepted beats pop the scoreboard; stalled beats must match its head.
    always @(negedge clk) begin : monitor
        logic [18:0] act;
        logic [18:0] exp_beat;
        if (rst_n && aso_valid) begin
            act = {aso_startofpacket, aso_endofpacket, aso_channel, aso_data};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("[TB] FAIL beat_unexpected actual=0x%05h required=none", act);
            end else if (aso_ready) begin
                exp_beat = exp_q.pop_front();
                if (act !== exp_beat) begin
                    failures++;
                    $display("[TB] FAIL beat actual=0x%05h required=0x%05h", act, exp_beat);
                end
            end else if (act !== exp_q[0]) begin
                failures++;
                $display("[TB] FAIL stall_hold actual=0x%05h required=0x%05h", act, exp_q[0]);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        #12;
        check_output("reset_valid", 32'(aso_valid), 32'h0);
        check_output("reset_data", 32'(aso_data), 32'h0);
        check_output("reset_sop_eop", 32'({aso_startofpacket, aso_endofpacket}), 32'h0);
        check_output("reset_readdata", avs_readdata, 32'h0);
        check_output("reset_irq", 32'(irq), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(1);

        read_check("status_after_reset", ADDR_STATUS, 32'h0002_0000);
        read_check("ctrl_after_reset", ADDR_CTRL, 32'h0);
        read_check("underrun_after_reset", ADDR_UNDERRUN, 32'h0);

        // Basic two-frame replay with a mid-frame stall.
        bus_write(ADDR_DATA, 32'h1111);
        bus_write(ADDR_DATA, 32'h2222);
        bus_write(ADDR_DATA, 32'h3333);
        bus_write(ADDR_DATA, 32'h4444);
        read_check("status_level2", ADDR_STATUS, 32'h0000_0002);
        push_frame(16'h1111, 16'h2222);
        push_frame(16'h3333, 16'h4444);
        stream_frames(2, 5);
        read_check("status_drained", ADDR_STATUS, 32'h0002_0000);
        read_check("underrun_none", ADDR_UNDERRUN, 32'h0);

        // Underrun: three silence frames from an empty FIFO.
        for (int i = 0; i < 3; i++) begin
            push_frame(16'h0000, 16'h0000);
        end
        stream_frames(3, 0);
        read_check("underrun_3", ADDR_UNDERRUN, 32'h3);
        bus_write(ADDR_UNDERRUN, 32'h0);
        read_check("underrun_cleared", ADDR_UNDERRUN, 32'h0);

        // Overflow: 65 frames into a 64-deep FIFO with EN low.
        for (int f = 0; f < 65; f++) begin
            bus_write(ADDR_DATA, 32'hC000 + 32'(f));
            bus_write(ADDR_DATA, 32'hD000 + 32'(f));
            if (f < 64) begin
                push_frame(16'hC000 + 16'(f), 16'hD000 + 16'(f));
            end
        end
        read_check("status_full_ovf", ADDR_STATUS, 32'h0005_0040);
        bus_write(ADDR_STATUS, 32'h0004_0000);
        read_check("status_ovf_cleared", ADDR_STATUS, 32'h0001_0040);
        stream_frames(64, 0);
        read_check("status_after_full_drain", ADDR_STATUS, 32'h0002_0000);

        // Flush discards a partial frame and resets the write slot.
        bus_write(ADDR_DATA, 32'h0001);
        bus_write(ADDR_DATA, 32'h0002);
        bus_write(ADDR_DATA, 32'h0003);
        read_check("status_before_flush", ADDR_STATUS, 32'h0000_0001);
        bus_write(ADDR_CTRL, 32'h2);
        read_check("status_after_flush", ADDR_STATUS, 32'h0002_0000);
        read_check("ctrl_flush_selfclear", ADDR_CTRL, 32'h0);
        bus_write(ADDR_DATA, 32'hAAAA);
        bus_write(ADDR_DATA, 32'hBBBB);
        read_check("status_after_refill", ADDR_STATUS, 32'h0000_0001);
        push_frame(16'hAAAA, 16'hBBBB);
        stream_frames(1, 0);

        // IRQ_EN storage and the low-watermark interrupt.
        bus_write(ADDR_CTRL, 32'h4);
`ifdef AUDIO_FRAME_STREAMER_IRQ_EN
        read_check("ctrl_irq_en", ADDR_CTRL, 32'h4);
        check_output("irq_en_without_en", 32'(irq), 32'h0);
        for (int f = 0; f < 20; f++) begin
            bus_write(ADDR_DATA, 32'h6000 + 32'(f));
            bus_write(ADDR_DATA, 32'h7000 + 32'(f));
            push_frame(16'h6000 + 16'(f), 16'h7000 + 16'(f));
        end
        read_check("status_level20", ADDR_STATUS, 32'h0000_0014);
        bus_write(ADDR_CTRL, 32'h5);
        wait_valid("irq_first_frame");
        for (int f = 0; f < 3; f++) begin
            aso_ready = 1'b1;
            tick(2);
            aso_ready = 1'b0;
            wait_valid("irq_drain_wait");
        end
        tick(2);
        check_output("irq_at_level16", 32'(irq), 32'h0);
        read_check("status_level16", ADDR_STATUS, 32'h0000_0010);
        aso_ready = 1'b1;
        tick(2);
        aso_ready = 1'b0;
        wait_valid("irq_drain_wait");
        tick(2);
        check_output("irq_at_level15", 32'(irq), 32'h1);
        read_check("status_level15_irq", ADDR_STATUS, 32'h0008_000F);
        bus_write(ADDR_DATA, 32'h6014);
        bus_write(ADDR_DATA, 32'h7014);
        push_frame(16'h6014, 16'h7014);
        tick(2);
        check_output("irq_after_refill", 32'(irq), 32'h0);
        bus_write(ADDR_CTRL, 32'h0);
        aso_ready = 1'b1;
        tick(2);
        aso_ready = 1'b0;
        tick(2);
        read_check("status_level16_idle", ADDR_STATUS, 32'h0000_0010);
        stream_frames(16, 0);
`else
        read_check("ctrl_irq_en_not_stored", ADDR_CTRL, 32'h0);
        check_output("irq_tied_low", 32'(irq), 32'h0);
        bus_write(ADDR_CTRL, 32'h5);
        push_frame(16'h0000, 16'h0000);
        wait_valid("irq_silence_wait");
        tick(2);
        check_output("irq_stays_low", 32'(irq), 32'h0);
        read_check("status_no_irq_bit", ADDR_STATUS, 32'h0002_0000);
        bus_write(ADDR_CTRL, 32'h0);
        aso_ready = 1'b1;
        tick(2);
        aso_ready = 1'b0;
        tick(2);
`endif
        bus_write(ADDR_CTRL, 32'h0);
        read_check("status_final", ADDR_STATUS, 32'h0002_0000);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            tick(1);
        end
        check_output("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/audio_frame_streamer.md
Name: audio_frame_streamer

Overview:
- Parametrised successor to the fixed stereo audio path. The HPS writes interleaved PCM samples over an Avalon-MM slave into a frame FIFO.
- The block replays those frames as an Avalon-ST channelised stream to the audio codec core.
- Generalised in channel count, sample width and depth. Adds underrun silence insertion, overflow detection, flush and a low-watermark interrupt.

Parameters:
- NUM_CH, 2, channels per frame (1..8).
- SAMPLE_W, 16, bits per sample (8..32); taken from writedata[SAMPLE_W-1:0].
- DEPTH, 64, FIFO depth in frames; power of 2, at least 4.
- LOW_WM, 16, watermark in frames for the interrupt; must be less than DEPTH.

Ports:
- clk_clk  in  1  single system clock.
- reset_reset_n  in  1  asynchronous, active-low reset.
- avs_address  in  2  register word address.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_read  in  1  read strobe.
- avs_readdata  out  32  read data, valid one cycle after avs_read.
- aso_data  out  SAMPLE_W  sample.
- aso_channel  out  CH_W  channel index; CH_W = max(1, clog2(NUM_CH)).
- aso_startofpacket  out  1  high on the channel-0 beat.
- aso_endofpacket  out  1  high on the channel NUM_CH-1 beat.
- aso_valid  out  1  stream valid.
- aso_ready  in  1  sink ready.
- irq  out  1  level interrupt.

Behaviour:
- Clock and reset: one clock, clk_clk. reset_reset_n is asynchronous active-low.
- Outputs in reset: all outputs 0; FIFO empty; CTRL=0; counters 0; wr_slot=0; FSM in IDLE.
- Register map:
  - Address 0, DATA (write-only): write stores the sample in assembly slot wr_slot, then wr_slot increments. On the write into slot NUM_CH-1, the frame is pushed and wr_slot wraps to 0. If the FIFO is full at push time, the frame is dropped and OVF is set.
  - Address 1, CTRL: bit0 EN; bit1 FLUSH (write 1, self-clearing, reads 0); bit2 IRQ_EN.
  - Address 2, STATUS (read-only except OVF): [15:0] level in frames; bit16 FULL; bit17 EMPTY; bit18 OVF (sticky, write 1 clears); bit19 irq.
  - Address 3, UNDERRUN: 16-bit saturating count of silence frames. Any write clears it.
- Reads: avs_readdata is registered with latency 1. Unmapped bits read 0.
- Level rules: push and pop in the same cycle leave level unchanged. Push is accepted when full if a pop occurs in the same cycle.
- Output FSM:
  - IDLE: aso_valid=0. When EN=1, go to LOAD.
  - LOAD (1 cycle): if the FIFO is non-empty, pop a frame into the output register. Otherwise load all-zero samples and increment UNDERRUN. Set ch=0, go to SEND.
  - SEND: aso_valid=1, aso_channel=ch, data=sample[ch]. On valid&&ready: if ch==NUM_CH-1, go to LOAD when EN=1, else IDLE; otherwise ch++.
  - A frame is never truncated. Clearing EN mid-frame completes the current frame first.
- Stream rules:
  - aso_data and aso_channel are stable while valid&&!ready.
  - Throughput is 1 beat per cycle within a frame, with 1 bubble per frame for LOAD.
- FLUSH: FIFO level and wr_slot are cleared the next cycle. A frame already in SEND completes. OVF and UNDERRUN are untouched. A DATA write in the same cycle as FLUSH is discarded.
- Reset mid-frame: stream aborts immediately, valid=0.

Optional Feature:
- Macro: AUDIO_FRAME_STREAMER_IRQ_EN.
- Defined: irq = IRQ_EN && EN && (level < LOW_WM || OVF). Registered, one cycle after the condition.
- Undefined: irq tied 0; CTRL bit2 is not stored and reads 0; STATUS bit19 reads 0.

Decomposition:
- Package audio_frame_streamer_pkg holds:
  - register address constants (ADDR_DATA/CTRL/STATUS/UNDERRUN);
  - CTRL/STATUS bit positions;
  - the FSM state enum (IDLE, LOAD, SEND);
  - the CH_W function.
- Sub-module frame_fifo: synchronous FIFO of NUM_CH*SAMPLE_W-bit words, DEPTH entries.
  - Provides push/pop, full/empty, and a level output of clog2(DEPTH)+1 bits.

Test Plan:
- NUM_CH=2: write 0x1111, 0x2222, 0x3333, 0x4444; EN=1; ready=1.
  -> Beats (ch0,0x1111,sop), (ch1,0x2222,eop), (ch0,0x3333), (ch1,0x4444). STATUS level 2 before EN, then 0.
- Hold ready=0 for 5 cycles mid-frame.
  -> data and channel held; no beat lost or duplicated.
- EN=1 with empty FIFO for 3 frames.
  -> 6 zero beats; UNDERRUN=3; write UNDERRUN -> reads 0.
- Write 65 full frames with EN=0, DEPTH=64.
  -> level 64, FULL=1, OVF=1, 65th frame absent. Write 1<<18 to STATUS -> OVF=0.
- Write 3 samples (NUM_CH=2), then FLUSH, then write 0xAAAA, 0xBBBB.
  -> level 1; frame content is {0xAAAA, 0xBBBB}.
- With AUDIO_FRAME_STREAMER_IRQ_EN defined: IRQ_EN=1, EN=1, level drops from 20 to 15 (LOW_WM=16).
  -> irq rises 1 cycle after level=15; refill to 16 -> irq falls. Without the macro, irq stays 0.
